pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised ready/valid pipeline stage register with a two-entry skid buffer, flush, and bubble gating of control bits. It generalises the fixed 16-bit stage registers of the pipelined CPU (EX→MEM and peers) into one reusable stage carrying a result word, a store-data word, a control vector and ALU flags. Back-pressure is supported without a combinational ready path from downstream to upstream. It sits between any two pipeline stages.

## Interface
- DATA_W, 16, width of result and store-data words
- CTRL_W, 2, control bits (bit0 RegWrite, bit1 MemWrite in the CPU)
- FLAG_W, 3, flag bits (bit0 Z, bit1 N, bit2 V)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered, depends only on skid state
- in_result, in_wdata  in  DATA_W  payload words
- in_ctrl  in  CTRL_W  control vector
- in_flags  in  FLAG_W  flags
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_result, out_wdata  out  DATA_W  payload words
- out_ctrl  out  CTRL_W  control vector, forced to 0 when out_valid=0
- out_flags  out  FLAG_W  flags
- stall_cnt  out  16  stall-cycle counter (see Configuration)

## Operation
- Storage: main register M (drives outputs) and skid register S, each with a valid bit.
- Transfers: input fire = in_valid & in_ready; output fire = out_valid & out_ready.
- in_ready = !S.valid.
- Input fire, and M empty or output fire: load M from the input. If S is valid, S loads M instead and the input goes to S (cannot occur, because in_ready=0 whenever S is valid).
- Input fire, M valid, and no output fire: load S.
- Output fire with S valid: S moves to M and S.valid clears; in_ready rises the next cycle.
- Output fire with no input fire and S empty: M.valid clears.
- Entries are never reordered, duplicated or dropped, except on flush.
- flush=1: next cycle M.valid=S.valid=0; any input fire in the same cycle is discarded; payload registers keep stale values.
- Reset (reset=0): all valid bits, payload registers and stall_cnt go to 0. Reset has priority over flush and over all transfers.
- out_ctrl = M.ctrl & {CTRL_W{out_valid}}, so a bubble never writes the register file or memory.

## Timing
- Latency: input fire in cycle n gives out_valid=1 with that payload in cycle n+1.
- Throughput: 1 entry/cycle while out_ready=1.
- out_ready low in cycle n: the entry accepted in cycle n goes to S; in_ready=0 from cycle n+1.
- out_ready high again in cycle k: S moves to M at the end of cycle k; in_ready=1 in cycle k+1.
- No combinational path from out_ready to in_ready.
- Reset values: in_ready=1, out_valid=0, out_result=0, out_wdata=0, out_ctrl=0, out_flags=0, stall_cnt=0.
- Reset released mid-stream: the first input fire is possible in the first cycle with reset=1.

## Configuration
- PIPE_STAGE_STALL_CNT_EN defined: stall_cnt increments on every cycle with out_valid=1 and out_ready=0. It saturates at 16'hFFFF, clears on reset, and is unaffected by flush.
- Not defined: stall_cnt is tied to 16'h0000 and no counter logic is built.

## Test plan
- Reset: hold reset=0 for 2 cycles with in_valid=1 → out_valid=0, out_ctrl=0, in_ready=1, all payload outputs 0.
- Streaming: out_ready=1, send results 16'h0001..16'h0004 back-to-back with ctrl=2'b01 → outputs 1..4 in order, one per cycle, one cycle later; in_ready stays 1.
- Back-pressure: send A=16'h00AA, B=16'h00BB, then drop out_ready for 3 cycles → out shows A steadily, B held in S, in_ready=0. Raise out_ready → A, then B on consecutive cycles, no loss or duplication.
- Flush: with M and S both full, assert flush plus input C=16'h00CC → next cycle out_valid=0, out_ctrl=2'b00, in_ready=1; C never appears.
- Bubble gating: M holds ctrl=2'b11, output fires, no new input → next cycle out_valid=0 and out_ctrl=2'b00.
- Counter: with the macro defined, stall for 5 cycles → stall_cnt=5. Preload via 65540 stall cycles → stall_cnt holds 16'hFFFF. With the macro undefined → stall_cnt=0 throughout.

Source files
------------

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Ready/valid pipeline stage register with a two-entry skid
//            buffer (main M + skid S), flush, and bubble gating of the
//            control vector. in_ready is a flop output, so there is no
//            combinational path from out_ready back to in_ready.
// Options  : PIPE_STAGE_STALL_CNT_EN - builds a saturating stall counter;
//            otherwise stall_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 2,
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_wdata,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [FLAG_W-1:0] out_flags,
  output logic [15:0]       stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] wdata;
    logic [CTRL_W-1:0] ctrl;
    logic [FLAG_W-1:0] flags;
  } entry_t;

  entry_t m_q, m_d, s_q, s_d;
  logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  entry_t in_entry;
  logic   in_fire, out_fire;

  // Pack the input payload and derive the handshake events
  always_comb begin
    in_entry.result = in_result;
    in_entry.wdata  = in_wdata;
    in_entry.ctrl   = in_ctrl;
    in_entry.flags  = in_flags;
    in_fire         = in_valid & ~s_valid_q;
    out_fire        = m_valid_q & out_ready;
  end

  // Next-state for M and S: keep order, refill M from S before taking input
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      // Payload stays stale; only the valid bits are killed.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (out_fire) begin
      if (s_valid_q) begin
        // in_ready is low while S is full, so no input can collide here.
        m_d       = s_q;
        s_valid_d = 1'b0;
      end else if (in_fire) begin
        m_d = in_entry;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!m_valid_q) begin
        m_d       = in_entry;
        m_valid_d = 1'b1;
      end else begin
        s_d       = in_entry;
        s_valid_d = 1'b1;
      end
    end
  end

  // Storage registers; reset clears valid bits and payloads
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  // Outputs straight from flops; ctrl gated so a bubble never commits
  always_comb begin
    in_ready   = ~s_valid_q;
    out_valid  = m_valid_q;
    out_result = m_q.result;
    out_wdata  = m_q.wdata;
    out_ctrl   = m_q.ctrl & {CTRL_W{m_valid_q}};
    out_flags  = m_q.flags;
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where an entry is presented but not taken; saturates
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Counter register; flush deliberately does not touch it
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Self-checking bench for pipe_stage_skid. A queue-based model
//            (at most two held entries, FIFO order) predicts the outputs;
//            a negedge process compares every cycle. Directed sequences add
//            literal expectations. Honours PIPE_STAGE_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  localparam int DATA_W = 16;
  localparam int CTRL_W = 2;
  localparam int FLAG_W = 3;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_result, in_wdata, out_result, out_wdata;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [FLAG_W-1:0] in_flags, out_flags;
  logic [15:0]       stall_cnt;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .FLAG_W(FLAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_wdata(in_wdata), .in_ctrl(in_ctrl), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_wdata(out_wdata), .out_ctrl(out_ctrl), .out_flags(out_flags),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] wdata;
    logic [CTRL_W-1:0] ctrl;
    logic [FLAG_W-1:0] flags;
  } ent_t;

  ent_t        mq[$];
  int          mcnt = 0;
  bit          check_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage behaves as a 2-deep FIFO that accepts
  // whenever fewer than two entries are held.
  always @(posedge clk) begin
    bit   ifire, ofire, stalled;
    ent_t e;
    ifire   = in_valid && (mq.size() < 2);
    ofire   = (mq.size() > 0) && out_ready;
    stalled = (mq.size() > 0) && !out_ready;
    if (!reset) begin
      mq.delete();
      mcnt = 0;
    end else begin
`ifdef PIPE_STAGE_STALL_CNT_EN
      if (stalled && mcnt < 65535) mcnt++;
`endif
      if (flush) begin
        mq.delete();
      end else begin
        if (ofire) void'(mq.pop_front());
        if (ifire) begin
          e.result = in_result; e.wdata = in_wdata;
          e.ctrl   = in_ctrl;   e.flags = in_flags;
          mq.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
      chk("m_in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
      chk("m_stall_cnt", {16'b0, stall_cnt}, mcnt);
      if (mq.size() > 0) begin
        chk("m_out_result", {16'b0, out_result}, {16'b0, mq[0].result});
        chk("m_out_wdata", {16'b0, out_wdata}, {16'b0, mq[0].wdata});
        chk("m_out_ctrl", {30'b0, out_ctrl}, {30'b0, mq[0].ctrl});
        chk("m_out_flags", {29'b0, out_flags}, {29'b0, mq[0].flags});
      end else begin
        chk("m_bubble_ctrl", {30'b0, out_ctrl}, 32'd0);
      end
    end
  end

  // Apply one cycle of stimulus, then land on the following negedge
  task automatic step(input logic v, input logic [15:0] res, input logic [1:0] c,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_result = res;
    in_wdata  = ~res;
    in_ctrl   = c;
    in_flags  = res[2:0];
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_result = 16'h1234; in_wdata = 16'h5678; in_ctrl = 2'b11; in_flags = 3'b111;

    // Reset held two cycles with in_valid=1
    @(posedge clk);
    check_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_ctrl", {30'b0, out_ctrl}, 32'd0);
    chk("rst_payload", {out_result, out_wdata}, 32'd0);
    chk("rst_flags", {29'b0, out_flags}, 32'd0);
    chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    reset = 1'b1;

    // Streaming 1..4, one cycle latency, in_ready stays high
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 16'(i), 2'b01, 1'b1, 1'b0);
      chk("stream_result", {16'b0, out_result}, i);
      chk("stream_ctrl", {30'b0, out_ctrl}, 32'd1);
      chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
    end
    step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    chk("stream_drain", {31'b0, out_valid}, 32'd0);

    // Back-pressure: A in M, B lands in S, hold three low cycles
    step(1'b1, 16'h00AA, 2'b01, 1'b1, 1'b0);
    step(1'b1, 16'h00BB, 2'b01, 1'b0, 1'b0);
    chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    step(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
    step(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
    chk("bp_hold_A", {16'b0, out_result}, 32'h00AA);
    chk("bp_in_ready_held", {31'b0, in_ready}, 32'd0);
    step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    chk("bp_then_B", {16'b0, out_result}, 32'h00BB);
    chk("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
    step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // Flush with M and S full plus input C
    step(1'b1, 16'h00D0, 2'b11, 1'b0, 1'b0);
    step(1'b1, 16'h00E0, 2'b11, 1'b0, 1'b0);
    step(1'b1, 16'h00CC, 2'b11, 1'b0, 1'b1);
    chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_out_ctrl", {30'b0, out_ctrl}, 32'd0);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
      chk("fl_no_C", {31'b0, out_valid}, 32'd0);
    end

    // Bubble gating after the last entry leaves
    step(1'b1, 16'h0077, 2'b11, 1'b1, 1'b0);
    chk("bub_ctrl_live", {30'b0, out_ctrl}, 32'd3);
    step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    chk("bub_valid", {31'b0, out_valid}, 32'd0);
    chk("bub_ctrl", {30'b0, out_ctrl}, 32'd0);

`ifdef PIPE_STAGE_STALL_CNT_EN
    reset = 1'b0;
    step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    reset = 1'b1;
    step(1'b1, 16'h0042, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
    chk("cnt_five", {16'b0, stall_cnt}, 32'd5);
    for (int i = 5; i < 65540; i++) step(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
    chk("cnt_saturate", {16'b0, stall_cnt}, 32'h0000FFFF);
    step(1'b0, 16'h0, 2'b00, 1'b0, 1'b1);
    chk("cnt_flush_keeps", {16'b0, stall_cnt}, 32'h0000FFFF);
    reset = 1'b0;
    step(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
    chk("cnt_reset", {16'b0, stall_cnt}, 32'd0);
    reset = 1'b1;
`else
    step(1'b1, 16'h0042, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
    chk("cnt_tied_zero", {16'b0, stall_cnt}, 32'd0);
`endif

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      step(($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
    end
    reset = 1'b1;

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
